hc_sr04_echo_responder: RTL

Behavioural responder for the HC-SR04 ultrasonic ranging protocol: it accepts the sensor's trigger pulse and returns an echo pulse whose width encodes a programmed distance (58 µs per cm). It stands in for the physical sensor in board-level loopback and simulation, so the ranging controller can be exercised against known distances. Distance comes from switches or a register; the echo output drives the controller's echo input directly.

---
 rtl/hc_sr04_echo_responder.sv | 102 ++++++++++
 1 files changed

// File: rtl/hc_sr04_echo_responder.sv
// hc_sr04_echo_responder: HC-SR04 stand-in that answers a trig pulse with an echo whose width encodes distance_cm.
// Ports: clk, reset_p (sync, active-high), trig (async in), distance_cm (cm to report),
//        echo (registered echo pulse), busy (high outside IDLE), trig_short (1-clk reject strobe),
//        captured_cm (distance latched for the current/last measurement).
module hc_sr04_echo_responder #(
    parameter int unsigned SYS_FREQ    = 100_000_000,
    parameter int unsigned MIN_TRIG_US = 10,
    parameter int unsigned BURST_US    = 200,
    parameter int unsigned MAX_CM      = 400,
    parameter int unsigned TIMEOUT_US  = 38000,
    parameter int unsigned HOLDOFF_US  = 1000
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       trig,
    input  logic [8:0] distance_cm,
    output logic       echo,
    output logic       busy,
    output logic       trig_short,
    output logic [8:0] captured_cm
);
    localparam int unsigned DIV = SYS_FREQ / 1_000_000;
    typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO, HOLDOFF} state_t;
    state_t      state;
    logic [1:0]  sync;
    logic        trig_q;
    logic [31:0] pre;
    logic [15:0] us_cnt, echo_len, cm16, cm58;
    logic        tick, rise, fall, trig_ok, in_range, sat;
    always_comb begin
        tick     = pre == 32'(DIV - 1);
        rise     = sync[1] & ~trig_q;
        fall     = ~sync[1] & trig_q;
        sat      = state == TRIG_HI && us_cnt >= 16'(MIN_TRIG_US);
        // the tick landing on the fall cycle still counts toward the trig width
        trig_ok  = us_cnt >= 16'(MIN_TRIG_US) || (tick && us_cnt == 16'(MIN_TRIG_US - 1));
        cm16     = {7'd0, captured_cm};
        cm58     = (cm16 << 5) + (cm16 << 4) + (cm16 << 3) + (cm16 << 1);
        in_range = captured_cm != 9'd0 && cm16 <= 16'(MAX_CM);
    end
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state       <= IDLE;
            sync        <= '0;
            trig_q      <= 1'b0;
            pre         <= '0;
            us_cnt      <= '0;
            echo_len    <= '0;
            echo        <= 1'b0;
            busy        <= 1'b0;
            trig_short  <= 1'b0;
            captured_cm <= '0;
        end else begin
            sync       <= {sync[0], trig};
            trig_q     <= sync[1];
            trig_short <= 1'b0;
            pre        <= tick ? '0 : pre + 32'd1;
            if (tick && !sat) us_cnt <= us_cnt + 16'd1;
            // every transition restarts the prescaler and us counter so durations count from state entry
            case (state)
                IDLE: if (rise) begin
                    state  <= TRIG_HI;
                    busy   <= 1'b1;
                    pre    <= '0;
                    us_cnt <= '0;
                end
                TRIG_HI: if (fall) begin
                    pre    <= '0;
                    us_cnt <= '0;
                    if (trig_ok) begin
                        captured_cm <= distance_cm;
                        state       <= BURST;
                    end else begin
                        trig_short <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                BURST: if (tick && us_cnt == 16'(BURST_US - 1)) begin
                    state    <= ECHO;
                    echo     <= 1'b1;
                    echo_len <= in_range ? cm58 : 16'(TIMEOUT_US);
                    pre      <= '0;
                    us_cnt   <= '0;
                end
                ECHO: if (tick && us_cnt == echo_len - 16'd1) begin
                    state  <= HOLDOFF;
                    echo   <= 1'b0;
                    pre    <= '0;
                    us_cnt <= '0;
                end
                HOLDOFF: if (tick && us_cnt == 16'(HOLDOFF_US - 1)) begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    pre    <= '0;
                    us_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
